mvm_result_drain: RTL

- Sits downstream of the MVM engine and consumes its per-job result beats: NUM_OLANES parallel OWIDTH results qualified by a single-cycle valid, with no backpressure.
- Buffers beats in a small FIFO and serializes them, one lane per transfer, onto a valid/ready stream toward the host/DMA.
- Marks the final word of each job with tlast and flags overflow when the downstream stalls too long.

---
 rtl/mvm_pkg.sv | 29 ++
 rtl/mvm_drain_fifo.sv | 73 +++++++
 rtl/mvm_result_drain.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// Shared types and default geometry for the MVM result drain path.
// MVM_DRAIN_TAG_EN adds a per-entry row index to the buffered beats.
package mvm_pkg;

    localparam int OWIDTH_DEF     = 32;
    localparam int NUM_OLANES_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ROWW_DEF       = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } drain_state_e;

    // Buffered beat at the default geometry; the drain top re-declares it with its own parameters.
    typedef struct packed {
        logic [NUM_OLANES_DEF*OWIDTH_DEF-1:0] lanes;
`ifdef MVM_DRAIN_TAG_EN
        logic [ROWW_DEF-1:0]                  row;
`endif
        logic                                 last;
    } entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mvm_drain_fifo.sv
// Register-array FIFO of full lane-vector beats; a push while full is
// accepted when a pop happens in the same cycle.
module mvm_drain_fifo
    import mvm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        data_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [cnt_w(DEPTH)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only read while count_q is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mvm_result_drain.sv
// Buffers MVM result beats and serializes them one lane per transfer onto a
// valid/ready stream. MVM_DRAIN_TAG_EN adds o_tuser = {row index, lane index}.
module mvm_result_drain
    import mvm_pkg::*;
#(
    parameter int OWIDTH     = OWIDTH_DEF,
    parameter int NUM_OLANES = NUM_OLANES_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ROWW       = ROWW_DEF
`ifdef MVM_DRAIN_TAG_EN
    ,
    parameter int TAGW       = ROWW + $clog2(NUM_OLANES)
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [ROWW-1:0]              i_num_rows,
    input  logic [NUM_OLANES*OWIDTH-1:0] i_result,
    input  logic                         i_valid,
    output logic [OWIDTH-1:0]            o_tdata,
    output logic                         o_tvalid,
    input  logic                         i_tready,
    output logic                         o_tlast,
`ifdef MVM_DRAIN_TAG_EN
    output logic [TAGW-1:0]              o_tuser,
`endif
    output logic                         o_busy,
    output logic                         o_overflow
);

    localparam int LW = $clog2(NUM_OLANES);
    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam logic [LW-1:0] LANE_LAST = LW'(NUM_OLANES - 1);

    typedef struct packed {
        logic [NUM_OLANES*OWIDTH-1:0] lanes;
`ifdef MVM_DRAIN_TAG_EN
        logic [ROWW-1:0]              row;
`endif
        logic                         last;
    } ent_t;

    drain_state_e    state_q, state_d;
    logic [ROWW-1:0] rows_q, rows_d;
    logic [ROWW-1:0] rcv_q, rcv_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic            ovf_q, ovf_d;

    ent_t            push_ent, head;
    logic            push, pop, hs;
    logic            f_empty, f_full;
    logic [CW-1:0]   f_count;

    mvm_drain_fifo #(
        .WIDTH ($bits(ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_ent),
        .data_o  (head),
        .empty_o (f_empty),
        .full_o  (f_full),
        .count_o (f_count)
    );

    always_comb begin
        state_d        = state_q;
        rows_d         = rows_q;
        rcv_d          = rcv_q;
        lane_d         = lane_q;
        ovf_d          = ovf_q;
        push           = 1'b0;
        pop            = 1'b0;
        hs             = !f_empty && i_tready;
        push_ent.lanes = i_result;
        push_ent.last  = (rcv_q == rows_q - 1'b1);
`ifdef MVM_DRAIN_TAG_EN
        push_ent.row   = rcv_q;
`endif

        if (hs) begin
            if (lane_q == LANE_LAST) begin
                lane_d = '0;
                pop    = 1'b1;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (i_start && i_num_rows != '0) begin
                    rows_d  = i_num_rows;
                    rcv_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (i_valid) begin
                    push  = 1'b1;
                    rcv_d = rcv_q + 1'b1;
                    // Same drop condition the FIFO applies internally.
                    if (f_full && !pop) begin
                        ovf_d = 1'b1;
                    end
                    if (rcv_q + 1'b1 == rows_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave on the final pop so o_busy drops right after the last handshake.
                if (f_empty || (pop && f_count == CW'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rows_q  <= '0;
            rcv_q   <= '0;
            lane_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            rcv_q   <= rcv_d;
            lane_q  <= lane_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_tvalid   = !f_empty;
    assign o_tdata    = f_empty ? '0 : head.lanes[lane_q*OWIDTH +: OWIDTH];
    assign o_tlast    = !f_empty && head.last && (lane_q == LANE_LAST);
    assign o_busy     = (state_q != IDLE);
    assign o_overflow = ovf_q;
`ifdef MVM_DRAIN_TAG_EN
    assign o_tuser    = f_empty ? '0 : {head.row, lane_q};
`endif

endmodule
